retire_wb_queue: RTL and testbench
==================================

RETIRE_WB_QUEUE -- requirements
Module: retire_wb_queue

Interface
REQ-001 SHALL have parameter ENTRY_WIDTH, default 32, meaning width of each write-data entry.
REQ-002 SHALL have parameter N_ARCH_REGS, default 32, meaning number of architectural registers; PTR_WIDTH = $clog2(N_ARCH_REGS).
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-004 SHALL have parameter N_FWD_PORTS, default 2, meaning number of forwarding lookup ports.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_aL, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports enq_valid (input, 1), enq_ready (output, 1), enq_addr (input, PTR_WIDTH) and enq_data (input, ENTRY_WIDTH), carrying retired results from the ROB.
REQ-008 SHALL have ports wr_en (output, 1), wr_addr (output, PTR_WIDTH) and wr_data (output, ENTRY_WIDTH), driving the regfile write port.
REQ-009 SHALL have port wr_gnt, input, 1: the regfile port accepts this cycle's write.
REQ-010 SHALL have ports fwd_addr (input, N_FWD_PORTS x PTR_WIDTH), fwd_hit (output, N_FWD_PORTS) and fwd_data (output, N_FWD_PORTS x ENTRY_WIDTH).
REQ-011 SHALL have port count, output, $clog2(DEPTH+1), number of occupied entries.

Function
REQ-012 SHALL be a circular FIFO with head and tail pointers of $clog2(DEPTH) bits; both wrap from DEPTH-1 to 0.
REQ-013 SHALL drive enq_ready = (count < DEPTH); no same-cycle pop pass-through when full.
REQ-014 SHALL define the enqueue fire as enq_valid & enq_ready.
REQ-015 SHALL store {enq_addr, enq_data} at tail, then advance tail, on an enqueue fire with enq_addr != 0.
REQ-016 SHALL accept an enqueue fire with enq_addr == 0 but drop it; no state changes.
REQ-017 SHALL drive wr_en = (count != 0), with wr_addr and wr_data taken from the head entry.
REQ-018 SHALL define the pop as wr_en & wr_gnt; a pop advances head.
REQ-019 SHALL handle a same-cycle store and pop by moving both pointers, leaving count unchanged.
REQ-020 SHALL leave wr_en, wr_addr and wr_data stable while wr_gnt is low (head held).
REQ-021 SHALL assert fwd_hit[i] combinationally iff fwd_addr[i] != 0 and a valid entry matches.
REQ-022 SHALL set fwd_data[i] to the youngest matching entry (closest to tail).
REQ-023 SHALL include the head entry in forwarding even in its pop cycle.
REQ-024 SHALL drive fwd_data[i] = 0 when fwd_hit[i] = 0.
REQ-025 SHALL exclude the same-cycle enqueue from forwarding (unless REQ-029).

Reset
REQ-026 SHALL, while rst_aL is low (asynchronous), clear head, tail and count to 0; entry storage is not reset.
REQ-027 SHALL hold these outputs during reset: wr_en=0, enq_ready=1, fwd_hit=0, fwd_data=0, count=0.
REQ-028 SHALL discard queued entries when reset asserts mid-operation; none are written.

Configuration
REQ-029 SHALL, with RETIRE_WB_QUEUE_BYPASS_EN defined and count==0, drive wr_en/wr_addr/wr_data directly from a nonzero-address enqueue fire.
REQ-030 SHALL, in the REQ-029 case, not store the entry if wr_gnt=1 and store it normally if wr_gnt=0.
REQ-031 SHALL, in the REQ-029 case, treat the entry as youngest for forwarding.
REQ-032 SHALL, without the macro, give one-cycle minimum enqueue-to-wr_en latency.

Structure
REQ-033 SHALL place PTR_WIDTH-derived constants and a packed wbq_entry_t {addr, data} typedef in shared package wbq_pkg.
REQ-034 SHALL use one sub-module, wbq_fwd_match: per-port compare against all entries, age-rotated by head, youngest selected via the existing ff1 block.

Verification
REQ-035 SHALL test: enqueue x5=0xA, x6=0xB with wr_gnt=1 -> wr_en next cycle, writes x5 then x6 on consecutive cycles, count returns to 0.
REQ-036 SHALL test: wr_gnt=0, enqueue 4 entries -> count=4, enq_ready=0, 5th enq_valid not accepted; one grant -> enq_ready=1 next cycle.
REQ-037 SHALL test: enqueue x3=0x1 then x3=0x2, fwd_addr[0]=3 -> fwd_hit[0]=1, fwd_data[0]=0x2; fwd_addr[1]=0 -> fwd_hit[1]=0.
REQ-038 SHALL test: enqueue x0=0xFFFF -> accepted, count stays 0, wr_en never asserts.
REQ-039 SHALL test: 10 alternating enq/pop cycles -> pointers wrap, regfile writes match enqueue order exactly.
REQ-040 SHALL test: rst_aL low with count=3 -> wr_en=0 and count=0 immediately, without waiting for a clock edge; no writes after release.

Source files
------------

// File: rtl/wbq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wbq_pkg                                                                |
// | Shared constants, entry type and find-first-one helper for the         |
// | retire write-back queue.                                               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package wbq_pkg;

    localparam int WBQ_N_ARCH_REGS = 32;
    localparam int WBQ_ENTRY_WIDTH = 32;
    localparam int WBQ_PTR_WIDTH   = $clog2(WBQ_N_ARCH_REGS);
    localparam int WBQ_FF1_MAX     = 64;

    typedef struct packed {
        logic [WBQ_PTR_WIDTH-1:0]   addr;
        logic [WBQ_ENTRY_WIDTH-1:0] data;
    } wbq_entry_t;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic int wbq_ff1(input logic [WBQ_FF1_MAX-1:0] vec);
        int idx;
        idx = 0;
        for (int i = WBQ_FF1_MAX - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbq_fwd_match.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wbq_fwd_match                                                          |
// | Per-port address match against all queue entries; returns the data    |
// | of the youngest valid match, ordered by age relative to head.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module wbq_fwd_match
    import wbq_pkg::*;
#(
    parameter  int ENTRY_WIDTH = 32,
    parameter  int PTR_WIDTH   = 5,
    parameter  int DEPTH       = 4,
    parameter  int N_FWD_PORTS = 2,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][PTR_WIDTH-1:0]         ent_addr_i,
    input  logic [DEPTH-1:0][ENTRY_WIDTH-1:0]       ent_data_i,
    input  logic [DEPTH-1:0]                        ent_valid_i,
    input  logic [IDX_W-1:0]                        head_i,
    input  logic [N_FWD_PORTS-1:0][PTR_WIDTH-1:0]   fwd_addr_i,
    output logic [N_FWD_PORTS-1:0]                  fwd_hit_o,
    output logic [N_FWD_PORTS-1:0][ENTRY_WIDTH-1:0] fwd_data_o
);

    localparam logic [IDX_W-1:0] LAST_AGE = IDX_W'(DEPTH - 1);

    for (genvar p = 0; p < N_FWD_PORTS; p++) begin : g_port
        logic [DEPTH-1:0]       match_age;
        logic [WBQ_FF1_MAX-1:0] rev;
        logic [IDX_W-1:0]       slot;
        logic [IDX_W-1:0]       sel;
        logic                   hit;
        logic [ENTRY_WIDTH-1:0] data;

        always_comb begin
            match_age = '0;
            rev       = '0;
            slot      = '0;
            // Bit k of match_age is the k-th oldest entry; reversing lets ff1 find the youngest.
            for (int k = 0; k < DEPTH; k++) begin
                slot         = head_i + IDX_W'(k);
                match_age[k] = ent_valid_i[slot]
                             && (ent_addr_i[slot] == fwd_addr_i[p])
                             && (fwd_addr_i[p] != '0);
            end
            for (int k = 0; k < DEPTH; k++) begin
                rev[k] = match_age[DEPTH-1-k];
            end
            sel  = head_i + LAST_AGE - IDX_W'(wbq_ff1(rev));
            hit  = |match_age;
            data = hit ? ent_data_i[sel] : '0;
        end

        assign fwd_hit_o[p]  = hit;
        assign fwd_data_o[p] = data;
    end

endmodule
`default_nettype wire

// File: rtl/retire_wb_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | retire_wb_queue                                                        |
// | Circular queue between ROB retirement and the regfile write port,      |
// | with youngest-match forwarding. Optional empty-queue bypass under      |
// | RETIRE_WB_QUEUE_BYPASS_EN.                                             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module retire_wb_queue
    import wbq_pkg::*;
#(
    parameter  int ENTRY_WIDTH = 32,
    parameter  int N_ARCH_REGS = 32,
    parameter  int DEPTH       = 4,
    parameter  int N_FWD_PORTS = 2,
    localparam int PTR_WIDTH   = $clog2(N_ARCH_REGS),
    localparam int IDX_W       = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst_aL,
    input  logic                                    enq_valid,
    output logic                                    enq_ready,
    input  logic [PTR_WIDTH-1:0]                    enq_addr,
    input  logic [ENTRY_WIDTH-1:0]                  enq_data,
    output logic                                    wr_en,
    output logic [PTR_WIDTH-1:0]                    wr_addr,
    output logic [ENTRY_WIDTH-1:0]                  wr_data,
    input  logic                                    wr_gnt,
    input  logic [N_FWD_PORTS-1:0][PTR_WIDTH-1:0]   fwd_addr,
    output logic [N_FWD_PORTS-1:0]                  fwd_hit,
    output logic [N_FWD_PORTS-1:0][ENTRY_WIDTH-1:0] fwd_data,
    output logic [CNT_W-1:0]                        count
);

    logic [IDX_W-1:0]                  head_q, head_d;
    logic [IDX_W-1:0]                  tail_q, tail_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic [DEPTH-1:0][PTR_WIDTH-1:0]   addr_q;
    logic [DEPTH-1:0][ENTRY_WIDTH-1:0] data_q;

    logic                              q_nonempty;
    logic                              enq_fire;
    logic                              store_req;
    logic                              store;
    logic                              q_pop;
    logic [DEPTH-1:0]                  ent_valid;
    logic [N_FWD_PORTS-1:0]            m_hit;
    logic [N_FWD_PORTS-1:0][ENTRY_WIDTH-1:0] m_data;

    assign q_nonempty = (count_q != '0);
    assign enq_ready  = (count_q < CNT_W'(DEPTH));
    assign enq_fire   = enq_valid & enq_ready;
    assign store_req  = enq_fire & (enq_addr != '0);
    assign q_pop      = q_nonempty & wr_gnt;
    assign count      = count_q;

`ifdef RETIRE_WB_QUEUE_BYPASS_EN
    logic byp;

    // Gated by reset so nothing leaks onto the write port while held in reset.
    assign byp     = store_req & ~q_nonempty & rst_aL;
    assign store   = store_req & ~(byp & wr_gnt);
    assign wr_en   = q_nonempty | byp;
    assign wr_addr = byp ? enq_addr : addr_q[head_q];
    assign wr_data = byp ? enq_data : data_q[head_q];

    for (genvar p = 0; p < N_FWD_PORTS; p++) begin : g_byp_fwd
        logic byp_hit;
        assign byp_hit     = byp & (fwd_addr[p] == enq_addr);
        assign fwd_hit[p]  = byp_hit | m_hit[p];
        assign fwd_data[p] = byp_hit ? enq_data : m_data[p];
    end
`else
    assign store    = store_req;
    assign wr_en    = q_nonempty;
    assign wr_addr  = addr_q[head_q];
    assign wr_data  = data_q[head_q];
    assign fwd_hit  = m_hit;
    assign fwd_data = m_data;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (store) tail_d = tail_q + IDX_W'(1);
        if (q_pop) head_d = head_q + IDX_W'(1);
        case ({store, q_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is deliberately left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[tail_q] <= enq_addr;
            data_q[tail_q] <= enq_data;
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_valid
        logic [IDX_W-1:0] rel;
        assign rel          = IDX_W'(j) - head_q;
        assign ent_valid[j] = (CNT_W'(rel) < count_q);
    end

    wbq_fwd_match #(
        .ENTRY_WIDTH (ENTRY_WIDTH),
        .PTR_WIDTH   (PTR_WIDTH),
        .DEPTH       (DEPTH),
        .N_FWD_PORTS (N_FWD_PORTS)
    ) u_fwd_match (
        .ent_addr_i  (addr_q),
        .ent_data_i  (data_q),
        .ent_valid_i (ent_valid),
        .head_i      (head_q),
        .fwd_addr_i  (fwd_addr),
        .fwd_hit_o   (m_hit),
        .fwd_data_o  (m_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_retire_wb_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_retire_wb_queue                                                     |
// | Directed self-checking bench for retire_wb_queue (default build).      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_retire_wb_queue;

    localparam int EW = 32;
    localparam int PW = 5;
    localparam int NF = 2;
    localparam int CW = 3;

    logic                   clk       = 1'b0;
    logic                   rst_aL    = 1'b0;
    logic                   enq_valid = 1'b0;
    logic                   enq_ready;
    logic [PW-1:0]          enq_addr  = '0;
    logic [EW-1:0]          enq_data  = '0;
    logic                   wr_en;
    logic [PW-1:0]          wr_addr;
    logic [EW-1:0]          wr_data;
    logic                   wr_gnt    = 1'b0;
    logic [NF-1:0][PW-1:0]  fwd_addr  = '0;
    logic [NF-1:0]          fwd_hit;
    logic [NF-1:0][EW-1:0]  fwd_data;
    logic [CW-1:0]          count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] log_addr[$];
    logic [EW-1:0] log_data[$];
    logic [PW-1:0] exp_addr[$];
    logic [EW-1:0] exp_data[$];

    always #5 clk = ~clk;

    retire_wb_queue #(
        .ENTRY_WIDTH (EW),
        .N_ARCH_REGS (32),
        .DEPTH       (4),
        .N_FWD_PORTS (NF)
    ) dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_addr  (enq_addr),
        .enq_data  (enq_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    // Record every write the regfile port accepts.
    always @(negedge clk) begin
        if (wr_en !== 1'b0 && wr_gnt) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic v, input logic [PW-1:0] a, input logic [EW-1:0] d);
        enq_valid = v;
        enq_addr  = a;
        enq_data  = d;
    endtask

    task automatic expect_wr(input logic [PW-1:0] a, input logic [EW-1:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    initial begin
        step();
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_enq_ready", enq_ready, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_fwd_hit", fwd_hit, 0);
        check_eq("rst_fwd_data", fwd_data, 0);
        rst_aL = 1'b1;

        // Two back-to-back retirements with the port always granting
        wr_gnt = 1'b1;
        drive_enq(1, 5'd5, 32'hA);
        expect_wr(5'd5, 32'hA);
        #1 check_eq("t1_wr_en_enq_cycle", wr_en, 0);
        step();
        check_eq("t1_count_a", count, 1);
        check_eq("t1_wr_en", wr_en, 1);
        check_eq("t1_wr_addr_a", wr_addr, 5);
        check_eq("t1_wr_data_a", wr_data, 32'hA);
        drive_enq(1, 5'd6, 32'hB);
        expect_wr(5'd6, 32'hB);
        step();
        check_eq("t1_count_b", count, 1);
        check_eq("t1_wr_addr_b", wr_addr, 6);
        check_eq("t1_wr_data_b", wr_data, 32'hB);
        drive_enq(0, '0, '0);
        step();
        check_eq("t1_count_end", count, 0);
        check_eq("t1_wr_en_end", wr_en, 0);

        // Fill to capacity with no grant
        wr_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_enq(1, 5'(i + 1), 32'h10 + i);
            expect_wr(5'(i + 1), 32'h10 + i);
            step();
        end
        check_eq("t2_count_full", count, 4);
        check_eq("t2_enq_ready_full", enq_ready, 0);
        check_eq("t2_head_addr", wr_addr, 1);
        check_eq("t2_head_data", wr_data, 32'h10);
        drive_enq(1, 5'd7, 32'h77);
        step();
        check_eq("t2_count_reject", count, 4);
        check_eq("t2_wr_en_held", wr_en, 1);
        check_eq("t2_head_addr_held", wr_addr, 1);
        drive_enq(0, '0, '0);
        wr_gnt = 1'b1;
        step();
        check_eq("t2_enq_ready_after_pop", enq_ready, 1);
        check_eq("t2_count_after_pop", count, 3);
        check_eq("t2_next_head_addr", wr_addr, 2);
        step();
        step();
        step();
        check_eq("t2_count_drained", count, 0);

        // Forwarding: youngest match, zero address, same-cycle enqueue, pop cycle
        wr_gnt = 1'b0;
        drive_enq(1, 5'd3, 32'h1);
        expect_wr(5'd3, 32'h1);
        step();
        drive_enq(1, 5'd3, 32'h2);
        expect_wr(5'd3, 32'h2);
        step();
        drive_enq(0, '0, '0);
        fwd_addr[0] = 5'd3;
        fwd_addr[1] = 5'd0;
        #1;
        check_eq("t3_hit0", fwd_hit[0], 1);
        check_eq("t3_data0_youngest", fwd_data[0], 32'h2);
        check_eq("t3_hit1_zero_addr", fwd_hit[1], 0);
        check_eq("t3_data1_zero_addr", fwd_data[1], 0);
        fwd_addr[1] = 5'd9;
        drive_enq(1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
        #1;
        check_eq("t3_hit1_same_cycle_enq", fwd_hit[1], 0);
        check_eq("t3_data1_same_cycle_enq", fwd_data[1], 0);
        step();
        drive_enq(0, '0, '0);
        #1;
        check_eq("t3_hit1_stored", fwd_hit[1], 1);
        check_eq("t3_data1_stored", fwd_data[1], 32'h99);
        wr_gnt = 1'b1;
        step();
        step();
        check_eq("t3_count_one_left", count, 1);
        check_eq("t3_hit0_after_pops", fwd_hit[0], 0);
        check_eq("t3_hit1_pop_cycle", fwd_hit[1], 1);
        check_eq("t3_data1_pop_cycle", fwd_data[1], 32'h99);
        step();
        check_eq("t3_count_end", count, 0);
        check_eq("t3_hit1_gone", fwd_hit[1], 0);
        fwd_addr = '0;

        // Write to x0 is accepted and dropped
        drive_enq(1, 5'd0, 32'hFFFF);
        #1 check_eq("t4_x0_ready", enq_ready, 1);
        step();
        drive_enq(0, '0, '0);
        check_eq("t4_x0_count", count, 0);
        check_eq("t4_x0_wr_en", wr_en, 0);
        step();
        check_eq("t4_x0_wr_en_later", wr_en, 0);

        // Continuous streaming wraps both pointers several times
        for (int k = 0; k < 10; k++) begin
            drive_enq(1, 5'(k + 16), 32'h100 + k);
            expect_wr(5'(k + 16), 32'h100 + k);
            step();
            check_eq("t5_count_stream", count, 1);
        end
        drive_enq(0, '0, '0);
        step();
        check_eq("t5_count_end", count, 0);

        // Youngest match straddling the wrap point (head sits at the last slot here)
        wr_gnt = 1'b0;
        drive_enq(1, 5'd8, 32'h81);
        expect_wr(5'd8, 32'h81);
        step();
        drive_enq(1, 5'd8, 32'h82);
        expect_wr(5'd8, 32'h82);
        step();
        drive_enq(0, '0, '0);
        fwd_addr[0] = 5'd8;
        #1;
        check_eq("t5_wrap_hit", fwd_hit[0], 1);
        check_eq("t5_wrap_youngest", fwd_data[0], 32'h82);
        wr_gnt = 1'b1;
        step();
        step();
        check_eq("t5_wrap_drained", count, 0);
        fwd_addr = '0;

        // Asynchronous reset mid-operation discards queued entries
        wr_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(1, 5'(10 + i), 32'h200 + i);
            step();
        end
        drive_enq(0, '0, '0);
        check_eq("t6_count_pre", count, 3);
        #2 rst_aL = 1'b0;
        #1;
        check_eq("t6_async_wr_en", wr_en, 0);
        check_eq("t6_async_count", count, 0);
        check_eq("t6_async_enq_ready", enq_ready, 1);
        step();
        wr_gnt = 1'b1;
        step();
        rst_aL = 1'b1;
        step();
        check_eq("t6_post_wr_en", wr_en, 0);
        step();
        check_eq("t6_post_count", count, 0);

        check_eq("n_writes", log_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            check_eq($sformatf("wr_addr[%0d]", i), log_addr[i], exp_addr[i]);
            check_eq($sformatf("wr_data[%0d]", i), log_data[i], exp_data[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
